alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Parametrised, sequential successor to the combinational ALU control decoder. Accepts one instruction per valid/ready handshake, decodes opcode/funct into the ALU control bundle, and emits a registered stream of micro-ops to the execute-stage ALU. Shift/rotate instructions are expanded into `shamt` single-bit micro-ops with result feedback. Sits between decode and the ALU in the execute stage.

## Interface
- `WIDTH`, 16, ALU datapath width; must be a power of two, ≥ 4.
- `SHAMT_W`, $clog2(WIDTH), shift-amount width (derived; do not override).
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: instruction offered.
- `in_ready` output 1: block can accept an instruction this cycle.
- `alu_op` input 5: instruction opcode field.
- `alu_funct` input 2: R-format function field.
- `shamt` input SHAMT_W: shift amount (register or immediate, pre-resolved upstream).
- `out_valid` output 1: micro-op bundle valid.
- `out_ready` input 1: ALU consumes micro-op.
- `invA`, `invB`, `sign`, `cin`, `passA`, `passB` output 1 each: ALU controls.
- `op_to_alu` output 3: 000 ROL, 001 SLL, 010 ROR, 011 SRL, 100 ADD, 101 OR, 110 XOR, 111 AND.
- `feedback` output 1: ALU takes operand A from its own previous result.
- `last` output 1: final micro-op of the current instruction.
- `illegal` output 1: current instruction's opcode/funct is undecoded.
- `busy` output 1: an instruction is in progress (state ≠ IDLE).

## Operation
- Decode map for single-micro-op instructions: HALT 00000 all-zero bundle; LBI 11000 passB; ADD 11011_00 ADD; SUB 11011_01 invA,cin,ADD; XOR 11011_10 XOR; ANDN 11011_11 invB,AND; SEQ 11100 invA,cin,ADD; SLT/SLE 11101/11110 invB,cin,ADD; SCO 11111 ADD; SLBI 10010 OR; ADDI 01000 sign,ADD; SUBI 01001 invA,cin,ADD; XORI 01010 XOR; ANDNI 01011 invB,AND.
- Shift class: R-form 11010 with funct 00/01/10/11 = ROL/SLL/ROR/SRL; I-form 10100/10101/10110/10111 = ROLI/SLLI/RORI/SRLI (funct ignored).
- Shift expansion, shamt = k: k > 0 emits k micro-ops with op_to_alu = shift code, each shifting by one; first has feedback=0, rest feedback=1; `last`=1 only on the k-th. k = 0 emits one micro-op with passA=1, op_to_alu=000, last=1.
- Any other opcode/funct: one all-zero micro-op with illegal=1, last=1.
- FSM: IDLE → ISSUE on single-op accept; IDLE → SHIFT on shift accept with k > 0 (count loaded with k); ISSUE → IDLE when micro-op consumed; SHIFT decrements count on each consume, → IDLE when the consumed micro-op had last=1.
- Output register: bundle held stable while out_valid && !out_ready.
- in_ready = (state == IDLE) || (last && out_valid && out_ready), i.e. the next instruction may be accepted in the cycle its predecessor's last micro-op is consumed (zero-bubble).
- Reset values: out_valid 0, every bundle bit 0, op_to_alu 000, last 0, illegal 0, busy 0, count 0, state IDLE; in_ready 1 once rst_n is high.

## Timing
- Accept at edge N (in_valid && in_ready) → first micro-op visible with out_valid=1 after edge N.
- With out_ready held 1: single op occupies 1 cycle; shift by k occupies k cycles; back-to-back instructions with no idle cycle.
- out_ready low stalls the count; nothing is skipped or duplicated.
- shamt = WIDTH−1: exactly WIDTH−1 micro-ops; count never wraps.
- rst_n asserted mid-shift: immediately clears out_valid and state; the partially issued instruction is dropped.
- in_valid while in_ready=0: ignored; upstream must hold.

## Structure
- Package `alu_ctrl_pkg`: opcode constants, `op_to_alu` encodings, FSM state enum, control-bundle struct.
- Sub-module `alu_op_decode`: purely combinational opcode/funct → {bundle, is_shift, illegal}; the sequencer instantiates it once on the input side.

## Test plan
- Reset: rst_n low mid-SHIFT with k=9 → out_valid 0 immediately; in_ready 1 and busy 0 after release.
- SUB (11011_01), out_ready=1 → one micro-op invA=1, cin=1, op=100, last=1, one cycle after accept.
- SLLI (10101), shamt=3, out_ready=1 → three micro-ops op=001, feedback 0,1,1, last 0,0,1; then ADD accepted on the 3rd cycle and issued next cycle.
- ROR, shamt=5, out_ready toggling 1,0,0,1,... → exactly 5 micro-ops, bundle stable during stalls.
- SRL shamt=0 → one micro-op passA=1, last=1; shamt=15 (WIDTH=16) → 15 micro-ops.
- Opcode 00111 → one micro-op illegal=1, all controls 0, last=1.

Source files
------------

// File: rtl/alu_seq_ctrl_pkg.sv
// Shared opcode map, ALU operation encodings, sequencer state and the
// control bundle that travels from decode to the execute-stage ALU.
package alu_ctrl_pkg;

   localparam logic [4:0] OP_HALT   = 5'b00000;
   localparam logic [4:0] OP_LBI    = 5'b11000;
   localparam logic [4:0] OP_RALU   = 5'b11011;
   localparam logic [4:0] OP_SEQ    = 5'b11100;
   localparam logic [4:0] OP_SLT    = 5'b11101;
   localparam logic [4:0] OP_SLE    = 5'b11110;
   localparam logic [4:0] OP_SCO    = 5'b11111;
   localparam logic [4:0] OP_SLBI   = 5'b10010;
   localparam logic [4:0] OP_ADDI   = 5'b01000;
   localparam logic [4:0] OP_SUBI   = 5'b01001;
   localparam logic [4:0] OP_XORI   = 5'b01010;
   localparam logic [4:0] OP_ANDNI  = 5'b01011;
   localparam logic [4:0] OP_RSHIFT = 5'b11010;
   localparam logic [4:0] OP_ROLI   = 5'b10100;
   localparam logic [4:0] OP_SLLI   = 5'b10101;
   localparam logic [4:0] OP_RORI   = 5'b10110;
   localparam logic [4:0] OP_SRLI   = 5'b10111;

   localparam logic [1:0] FN_ADD  = 2'b00;
   localparam logic [1:0] FN_SUB  = 2'b01;
   localparam logic [1:0] FN_XOR  = 2'b10;
   localparam logic [1:0] FN_ANDN = 2'b11;

   localparam logic [2:0] ALU_ROL = 3'b000;
   localparam logic [2:0] ALU_SLL = 3'b001;
   localparam logic [2:0] ALU_ROR = 3'b010;
   localparam logic [2:0] ALU_SRL = 3'b011;
   localparam logic [2:0] ALU_ADD = 3'b100;
   localparam logic [2:0] ALU_OR  = 3'b101;
   localparam logic [2:0] ALU_XOR = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_SHIFT = 2'b10
   } seq_state_e;

   typedef struct packed {
      logic       inv_a;
      logic       inv_b;
      logic       sign;
      logic       cin;
      logic       pass_a;
      logic       pass_b;
      logic [2:0] op;
   } alu_ctrl_t;

   localparam alu_ctrl_t CTRL_ZERO = '0;

   function automatic alu_ctrl_t mk_ctrl(
      input logic       inv_a,
      input logic       inv_b,
      input logic       sign,
      input logic       cin,
      input logic [2:0] op
   );
      alu_ctrl_t c;
      c        = CTRL_ZERO;
      c.inv_a  = inv_a;
      c.inv_b  = inv_b;
      c.sign   = sign;
      c.cin    = cin;
      c.op     = op;
      return c;
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode/funct decode into the ALU control bundle; shift
// instructions report their shift code in the bundle's op field.
module alu_op_decode
   import alu_ctrl_pkg::*;
(
   input  logic [4:0] alu_op,
   input  logic [1:0] alu_funct,
   output alu_ctrl_t  ctrl,
   output logic       is_shift,
   output logic       illegal
);

   always_comb begin
      ctrl     = CTRL_ZERO;
      is_shift = 1'b0;
      illegal  = 1'b0;
      case (alu_op)
         OP_HALT:  ctrl = CTRL_ZERO;
         OP_LBI:   ctrl.pass_b = 1'b1;
         OP_RALU: begin
            case (alu_funct)
               FN_ADD:  ctrl = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD);
               FN_SUB:  ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b1, ALU_ADD);
               FN_XOR:  ctrl = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, ALU_XOR);
               FN_ANDN: ctrl = mk_ctrl(1'b0, 1'b1, 1'b0, 1'b0, ALU_AND);
               default: illegal = 1'b1;
            endcase
         end
         OP_SEQ:            ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b1, ALU_ADD);
         OP_SLT, OP_SLE:    ctrl = mk_ctrl(1'b0, 1'b1, 1'b0, 1'b1, ALU_ADD);
         OP_SCO:            ctrl = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD);
         OP_SLBI:           ctrl = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, ALU_OR);
         OP_ADDI:           ctrl = mk_ctrl(1'b0, 1'b0, 1'b1, 1'b0, ALU_ADD);
         OP_SUBI:           ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b1, ALU_ADD);
         OP_XORI:           ctrl = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, ALU_XOR);
         OP_ANDNI:          ctrl = mk_ctrl(1'b0, 1'b1, 1'b0, 1'b0, ALU_AND);
         // funct order matches the shift encodings ROL/SLL/ROR/SRL directly
         OP_RSHIFT: begin
            is_shift = 1'b1;
            ctrl.op  = {1'b0, alu_funct};
         end
         OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: begin
            is_shift = 1'b1;
            ctrl.op  = {1'b0, alu_op[1:0]};
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Execute-stage ALU sequencer: accepts one instruction per handshake and
// streams registered micro-ops, expanding shifts into single-bit steps.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no instruction in flight, output empty, ready for input
//   ST_ISSUE | single micro-op (incl. illegal / zero shift) awaiting consume
//   ST_SHIFT | shift expansion; count_q = micro-ops left including current
module alu_seq_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [4:0]         alu_op,
   input  logic [1:0]         alu_funct,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               invA,
   output logic               invB,
   output logic               sign,
   output logic               cin,
   output logic               passA,
   output logic               passB,
   output logic [2:0]         op_to_alu,
   output logic               feedback,
   output logic               last,
   output logic               illegal,
   output logic               busy
);

   seq_state_e         state_q,     state_d;
   logic [SHAMT_W-1:0] count_q,     count_d;
   logic               out_valid_q, out_valid_d;
   alu_ctrl_t          ctrl_q,      ctrl_d;
   logic               feedback_q,  feedback_d;
   logic               last_q,      last_d;
   logic               illegal_q,   illegal_d;

   alu_ctrl_t dec_ctrl;
   logic      dec_is_shift;
   logic      dec_illegal;
   logic      accept;
   logic      consume;
   logic      shift_start;

   alu_op_decode u_decode (
      .alu_op    (alu_op),
      .alu_funct (alu_funct),
      .ctrl      (dec_ctrl),
      .is_shift  (dec_is_shift),
      .illegal   (dec_illegal)
   );

   assign consume     = out_valid_q && out_ready;
   assign in_ready    = (state_q == ST_IDLE) || (last_q && consume);
   assign accept      = in_valid && in_ready;
   assign shift_start = dec_is_shift && (shamt != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         ctrl_q      <= CTRL_ZERO;
         feedback_q  <= 1'b0;
         last_q      <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         ctrl_q      <= ctrl_d;
         feedback_q  <= feedback_d;
         last_q      <= last_d;
         illegal_q   <= illegal_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_ISSUE: if (consume) state_d = ST_IDLE;
         ST_SHIFT: if (consume && last_q) state_d = ST_IDLE;
         default:  state_d = state_q;
      endcase
      // an accept can coincide with the predecessor's final consume
      if (accept) begin
         state_d = shift_start ? ST_SHIFT : ST_ISSUE;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      ctrl_d      = ctrl_q;
      feedback_d  = feedback_q;
      last_d      = last_q;
      illegal_d   = illegal_q;
      count_d     = count_q;

      if (consume) begin
         if (state_q == ST_SHIFT && !last_q) begin
            count_d    = count_q - SHAMT_W'(1);
            feedback_d = 1'b1;
            last_d     = (count_q == SHAMT_W'(2));
         end else begin
            out_valid_d = 1'b0;
            ctrl_d      = CTRL_ZERO;
            feedback_d  = 1'b0;
            last_d      = 1'b0;
            illegal_d   = 1'b0;
            count_d     = '0;
         end
      end

      if (accept) begin
         out_valid_d = 1'b1;
         feedback_d  = 1'b0;
         illegal_d   = dec_illegal;
         count_d     = '0;
         if (shift_start) begin
            ctrl_d  = dec_ctrl;
            last_d  = (shamt == SHAMT_W'(1));
            count_d = shamt;
         end else if (dec_is_shift) begin
            // zero-distance shift degenerates to a pass-through of A
            ctrl_d        = CTRL_ZERO;
            ctrl_d.pass_a = 1'b1;
            ctrl_d.op     = ALU_ROL;
            last_d        = 1'b1;
         end else begin
            ctrl_d = dec_ctrl;
            last_d = 1'b1;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign invA      = ctrl_q.inv_a;
   assign invB      = ctrl_q.inv_b;
   assign sign      = ctrl_q.sign;
   assign cin       = ctrl_q.cin;
   assign passA     = ctrl_q.pass_a;
   assign passB     = ctrl_q.pass_b;
   assign op_to_alu = ctrl_q.op;
   assign feedback  = feedback_q;
   assign last      = last_q;
   assign illegal   = illegal_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: expected micro-ops are queued when an
// instruction is offered and compared as the ALU side consumes them.
module tb_alu_seq_ctrl;

   localparam int WIDTH   = 16;
   localparam int SHAMT_W = $clog2(WIDTH);

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [4:0]         alu_op = '0;
   logic [1:0]         alu_funct = '0;
   logic [SHAMT_W-1:0] shamt = '0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic               invA, invB, sign, cin, passA, passB;
   logic [2:0]         op_to_alu;
   logic               feedback, last, illegal, busy;

   int checks = 0;
   int errors = 0;
   int pops   = 0;

   // {invA,invB,sign,cin,passA,passB,op[2:0],feedback,last,illegal}
   logic [11:0] sb[$];

   alu_seq_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .alu_funct (alu_funct),
      .shamt     (shamt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .invA      (invA),
      .invB      (invB),
      .sign      (sign),
      .cin       (cin),
      .passA     (passA),
      .passB     (passB),
      .op_to_alu (op_to_alu),
      .feedback  (feedback),
      .last      (last),
      .illegal   (illegal),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] uop_now();
      return {invA, invB, sign, cin, passA, passB, op_to_alu, feedback, last, illegal};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference decode: ctrl = {invA,invB,sign,cin,passA,passB,op}
   task automatic ref_decode(input logic [4:0] op, input logic [1:0] fn,
                             output logic [8:0] ctrl, output bit shf, output bit ill);
      ctrl = 9'b0; shf = 1'b0; ill = 1'b0;
      case (op)
         5'b00000: ctrl = 9'b000000_000;
         5'b11000: ctrl = 9'b000001_000;
         5'b11011: case (fn)
                      2'b00: ctrl = 9'b000000_100;
                      2'b01: ctrl = 9'b100100_100;
                      2'b10: ctrl = 9'b000000_110;
                      default: ctrl = 9'b010000_111;
                   endcase
         5'b11100: ctrl = 9'b100100_100;
         5'b11101: ctrl = 9'b010100_100;
         5'b11110: ctrl = 9'b010100_100;
         5'b11111: ctrl = 9'b000000_100;
         5'b10010: ctrl = 9'b000000_101;
         5'b01000: ctrl = 9'b001000_100;
         5'b01001: ctrl = 9'b100100_100;
         5'b01010: ctrl = 9'b000000_110;
         5'b01011: ctrl = 9'b010000_111;
         5'b11010: begin shf = 1'b1; ctrl = {6'b0, 1'b0, fn}; end
         5'b10100: begin shf = 1'b1; ctrl = 9'b000000_000; end
         5'b10101: begin shf = 1'b1; ctrl = 9'b000000_001; end
         5'b10110: begin shf = 1'b1; ctrl = 9'b000000_010; end
         5'b10111: begin shf = 1'b1; ctrl = 9'b000000_011; end
         default:  ill = 1'b1;
      endcase
   endtask

   task automatic push_expected(input logic [4:0] op, input logic [1:0] fn, input int k);
      logic [8:0] c;
      bit         s, il;
      ref_decode(op, fn, c, s, il);
      if (il)
         sb.push_back({9'b0, 1'b0, 1'b1, 1'b1});
      else if (s && k == 0)
         sb.push_back({9'b000010_000, 1'b0, 1'b1, 1'b0});
      else if (s)
         for (int i = 1; i <= k; i++)
            sb.push_back({c, (i > 1) ? 1'b1 : 1'b0, (i == k) ? 1'b1 : 1'b0, 1'b0});
      else
         sb.push_back({c, 1'b0, 1'b1, 1'b0});
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [4:0] op, input logic [1:0] fn, input int k);
      int n;
      alu_op    = op;
      alu_funct = fn;
      shamt     = SHAMT_W'(k);
      in_valid  = 1'b1;
      push_expected(op, fn, k);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 200);
      if (!in_ready) chk("send_timeout", in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(tag, sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         logic [11:0] got, exp;
         got = uop_now();
         checks++;
         pops++;
         if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_unexpected observed=%03h expected=none", got);
         end else begin
            exp = sb.pop_front();
            assert (got === exp) else begin
               errors++;
               $error("FAIL uop observed=%03h expected=%03h", got, exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] snap;
      bit          have_snap;
      int          p0;

      rst_n = 1'b1;
      #3 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_bundle", uop_now(), 0);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // SUB: one micro-op one cycle after accept, occupying one cycle
      send(5'b11011, 2'b01, 0);
      @(negedge clk);
      chk("sub_valid", out_valid, 1);
      chk("sub_ctrl", {invA, cin, op_to_alu, last}, {1'b1, 1'b1, 3'b100, 1'b1});
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("sub_one_cycle", out_valid, 0);
      @(posedge clk);
      #1;

      // SLLI by 3, then ADD accepted in the cycle the last step is consumed
      send(5'b10101, 2'b00, 3);
      alu_op = 5'b11011; alu_funct = 2'b00; shamt = '0; in_valid = 1'b1;
      push_expected(5'b11011, 2'b00, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("slli_valid", out_valid, 1);
         chk("slli_in_ready", in_ready, (i == 2) ? 1 : 0);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk("add_no_bubble", out_valid, 1);
      chk("add_op", op_to_alu, 3'b100);
      wait_drain("slli_add_drain");

      // ROR by 5 with out_ready 1,0,0,1,0,0...
      p0 = pops;
      send(5'b11010, 2'b10, 5);
      for (int i = 0; i < 60 && sb.size() != 0; i++) begin
         out_ready = (i % 3 == 0);
         @(negedge clk);
         have_snap = out_valid && !out_ready;
         snap = uop_now();
         @(posedge clk);
         #1;
         if (have_snap) chk("ror_stall_stable", uop_now(), snap);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("ror_done_idle", out_valid, 0);
      chk("ror_count", pops - p0, 5);
      chk("ror_sb_empty", sb.size(), 0);
      @(posedge clk);
      #1;

      // SRL by 0 is a single pass-A micro-op; SRLI by WIDTH-1
      send(5'b11010, 2'b11, 0);
      @(negedge clk);
      chk("srl0_passA", {passA, last, op_to_alu}, {1'b1, 1'b1, 3'b000});
      wait_drain("srl0_drain");
      p0 = pops;
      send(5'b10111, 2'b00, WIDTH - 1);
      wait_drain("srli15_drain");
      chk("srli15_count", pops - p0, WIDTH - 1);
      @(negedge clk);
      chk("srli15_idle", busy, 0);
      @(posedge clk);
      #1;

      // Undecoded opcode
      send(5'b00111, 2'b00, 0);
      @(negedge clk);
      chk("illegal_uop", uop_now(), {9'b0, 1'b0, 1'b1, 1'b1});
      wait_drain("illegal_drain");

      // Back-to-back sweep of the remaining single-op map
      send(5'b00000, 2'b00, 0);
      send(5'b11000, 2'b10, 0);
      send(5'b11011, 2'b10, 0);
      send(5'b11011, 2'b11, 0);
      send(5'b11100, 2'b00, 0);
      send(5'b11101, 2'b00, 0);
      send(5'b11110, 2'b00, 0);
      send(5'b11111, 2'b00, 0);
      send(5'b10010, 2'b00, 0);
      send(5'b01000, 2'b00, 0);
      send(5'b01001, 2'b00, 0);
      send(5'b01010, 2'b00, 0);
      send(5'b01011, 2'b00, 0);
      send(5'b10100, 2'b00, 2);
      send(5'b10110, 2'b01, 1);
      send(5'b01100, 2'b00, 0);
      wait_drain("sweep_drain");

      // Reset asserted in the middle of a 9-step shift
      send(5'b10111, 2'b00, 9);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("midshift_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("midshift_rst_valid", out_valid, 0);
      chk("midshift_rst_busy", busy, 0);
      sb.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_busy", busy, 0);
      send(5'b01000, 2'b00, 0);
      wait_drain("post_rst_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
